dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single-port 1024-word data memory between the processor core (load/store) and a host/debug loader port.
- Each requester runs a hold-until-ack handshake. The arbiter serialises accesses, drives the memory port, registers read data and returns a one-cycle ack.
- Sits between the core's memory-access stage and the data memory. `core_stall` freezes the PC and pipeline while the core's access is pending.

Parameters:
- ADDR_W, 10, word-address width; the memory is indexed by word, so byte address bits [11:2] map to this.
- DATA_W, 32, data width.
- LAT, 1, memory read latency in cycles after the issue cycle; legal range 1..15.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- core_req  in  1  core access request; held with addr/we/wdata until core_ack.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  ADDR_W  word address.
- core_wdata  in  DATA_W  write data.
- core_ack  out  1  one-cycle completion pulse.
- core_rdata  out  DATA_W  registered read data; valid from the core_ack cycle until the next core read completes.
- core_stall  out  1  core_req & ~core_ack (combinational).
- host_req  in  1  host access request.
- host_we  in  1  host write enable.
- host_addr  in  ADDR_W  host word address.
- host_wdata  in  DATA_W  host write data.
- host_ack  out  1  host completion pulse.
- host_rdata  out  DATA_W  host registered read data.
- mem_en  out  1  memory enable; one-cycle pulse per access.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid LAT cycles after the mem_en cycle.
- busy  out  1  high in any state other than IDLE.
- conflict_cnt  out  CNT_W  count of IDLE cycles in which both requests were high.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; mem_en, mem_we, core_ack, host_ack, busy = 0; mem_addr, mem_wdata, both rdata = 0; last_gnt = 0 (core); conflict_cnt = 0; wait counter = 0.
- Reset mid-access: the state machine aborts immediately and mem_en drops. A write in flight is not guaranteed to complete. No ack is issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req lines are sampled only in this state.
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the port that is not last_gnt (round-robin), and increment conflict_cnt, saturating at all-ones.
  - On a grant: latch sel, we, addr and wdata from the winner; set last_gnt = winner; go to ISSUE.
- ISSUE (1 cycle): mem_en = 1; mem_we, mem_addr and mem_wdata come from the latched registers. Load counter = LAT; go to WAIT.
- WAIT:
  - Decrement the counter each cycle; mem_en = 0.
  - When the counter reaches 1, that cycle's mem_rdata is valid. Capture it into the selected port's rdata register at the end of the cycle, then go to RESP.
  - Writes also spend LAT cycles in WAIT but capture nothing; rdata keeps its old value.
- RESP (1 cycle): the selected port's ack = 1; the other ack = 0. Go to IDLE.
- Latency:
  - req high in IDLE at cycle N.
  - mem_en at cycle N+1.
  - Data captured at the end of cycle N+LAT+1.
  - ack at cycle N+LAT+2.
  - Back in IDLE at cycle N+LAT+3.
- Throughput: one access per LAT+3 cycles.
- Handshake:
  - A requester holds req and its qualifiers stable until it sees ack.
  - A req still high in the cycle after ack is treated as a new transaction, with the address sampled then.
  - A requester that drops req before ack while not granted is simply never served.
  - Dropping req after grant does not cancel the access; ack is still pulsed.
- Both acks are never high together. mem_en is never high outside ISSUE.
- Inputs of the non-selected port are ignored while busy.

Test Plan:
- Core read, LAT=1, mem holds 0xDEADBEEF at addr 0x005, core_req at cycle 0 → mem_en=1 with mem_addr=0x005, mem_we=0 at cycle 1; core_ack at cycle 3 with core_rdata=0xDEADBEEF; core_stall high for cycles 0-2.
- Host write, addr 0x3FF, data 0x12345678, then core read of 0x3FF → the host ack arrives, and the core then reads back 0x12345678. host_rdata is unchanged by the write.
- Both req high continuously from reset, LAT=2 → grants alternate host, core, host, ...; acks arrive 5 cycles apart and are never simultaneous; conflict_cnt increments on each contended IDLE cycle.
- LAT=4 sweep → core_ack arrives exactly 6 cycles after req; mem_en is high for exactly 1 cycle per access.
- Assert rst low during WAIT of a core read → all outputs go to 0 asynchronously, no ack is pulsed, and after release a fresh core_req completes normally with last_gnt = core.
- Force conflict_cnt near saturation (CNT_W=4, 17 contended grants) → the count holds at 15.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Serialises core and host accesses, registers read data and pulses a per-port ack.
module dmem_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LAT    = 1,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_core_req,
    input  logic              i_core_we,
    input  logic [ADDR_W-1:0] i_core_addr,
    input  logic [DATA_W-1:0] i_core_wdata,
    output logic              o_core_ack,
    output logic [DATA_W-1:0] o_core_rdata,
    output logic              o_core_stall,
    input  logic              i_host_req,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    output logic              o_host_ack,
    output logic [DATA_W-1:0] o_host_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_conflict_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] LAT_CNT = 4'(LAT);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_sel;          // 0 = core, 1 = host
    logic                r_last_gnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [3:0]          r_wait_cnt;
    logic [CNT_W-1:0]    r_conflict;
    logic [DATA_W-1:0]   r_core_rdata;
    logic [DATA_W-1:0]   r_host_rdata;

    logic                w_both;
    logic                w_grant;
    logic                w_winner;
    logic                w_capture;
    logic                w_mem_en;
    logic                w_mem_we;
    logic                w_core_ack;
    logic                w_host_ack;
    logic                w_busy;

    assign w_both    = i_core_req & i_host_req;
    assign w_grant   = (r_state == S_IDLE) & (i_core_req | i_host_req);
    // On contention the port that did not win last time goes first.
    assign w_winner  = w_both ? ~r_last_gnt : i_host_req;
    assign w_capture = (r_state == S_WAIT) & (r_wait_cnt == 4'd1) & ~r_we;

    always_comb begin
        w_state_next = r_state;
        w_mem_en     = 1'b0;
        w_mem_we     = 1'b0;
        w_core_ack   = 1'b0;
        w_host_ack   = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (w_grant) w_state_next = S_ISSUE;
            end
            S_ISSUE: begin
                w_mem_en     = 1'b1;
                w_mem_we     = r_we;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (r_wait_cnt == 4'd1) w_state_next = S_RESP;
            end
            S_RESP: begin
                w_core_ack   = ~r_sel;
                w_host_ack   = r_sel;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_sel        <= 1'b0;
            r_last_gnt   <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wait_cnt   <= '0;
            r_conflict   <= '0;
            r_core_rdata <= '0;
            r_host_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_grant) begin
                r_sel      <= w_winner;
                r_last_gnt <= w_winner;
                r_we       <= w_winner ? i_host_we    : i_core_we;
                r_addr     <= w_winner ? i_host_addr  : i_core_addr;
                r_wdata    <= w_winner ? i_host_wdata : i_core_wdata;
                if (w_both && !(&r_conflict))
                    r_conflict <= r_conflict + CNT_W'(1);
            end
            if (r_state == S_ISSUE)
                r_wait_cnt <= LAT_CNT;
            else if (r_state == S_WAIT)
                r_wait_cnt <= r_wait_cnt - 4'd1;
            if (w_capture) begin
                if (r_sel) r_host_rdata <= i_mem_rdata;
                else       r_core_rdata <= i_mem_rdata;
            end
        end
    end

    assign o_core_ack     = w_core_ack;
    assign o_host_ack     = w_host_ack;
    assign o_core_stall   = i_core_req & ~w_core_ack;
    assign o_core_rdata   = r_core_rdata;
    assign o_host_rdata   = r_host_rdata;
    assign o_mem_en       = w_mem_en;
    assign o_mem_we       = w_mem_we;
    assign o_mem_addr     = r_addr;
    assign o_mem_wdata    = r_wdata;
    assign o_busy         = w_busy;
    assign o_conflict_cnt = r_conflict;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed table, contention/reset sequences,
// and random traffic against a transaction-timeline reference model.
module tb_dmem_port_arbiter;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 32;
    localparam int LAT     = 2;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              core_req, core_we, core_ack, core_stall;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata, core_rdata;
    logic              host_req, host_we, host_ack;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata, host_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              busy;
    logic [CNT_W-1:0]  conflict_cnt;

    int n_vec = 0;
    int n_err = 0;

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT(LAT), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_core_req(core_req), .i_core_we(core_we), .i_core_addr(core_addr),
        .i_core_wdata(core_wdata), .o_core_ack(core_ack), .o_core_rdata(core_rdata),
        .o_core_stall(core_stall),
        .i_host_req(host_req), .i_host_we(host_we), .i_host_addr(host_addr),
        .i_host_wdata(host_wdata), .o_host_ack(host_ack), .o_host_rdata(host_rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
        .o_busy(busy), .o_conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: read data appears exactly LAT cycles after the enable cycle,
    // with random garbage on every other cycle.
    function automatic logic [DATA_W-1:0] init_word(int a);
        if (a == 5) return 32'hDEADBEEF;
        return 32'h5A000000 ^ (32'(a) * 32'h00010001);
    endfunction

    logic              init_go;
    logic [DATA_W-1:0] phys_mem [0:1023];
    logic [DATA_W-1:0] rd_pipe  [0:LAT-1];

    always @(posedge clk) begin
        if (init_go) begin
            for (int a = 0; a < 1024; a++) phys_mem[a] <= init_word(a);
        end else if (mem_en && mem_we) begin
            phys_mem[mem_addr] <= mem_wdata;
        end
        rd_pipe[0] <= (mem_en && !mem_we) ? phys_mem[mem_addr] : $urandom;
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic              host;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] exp_rdata;
    } vec_t;

    vec_t tbl [9];

    task automatic do_txn(input vec_t v, input int idx);
        @(posedge clk); #1;
        if (v.host) begin
            host_req = 1'b1; host_we = v.we; host_addr = v.addr; host_wdata = v.wdata;
        end else begin
            core_req = 1'b1; core_we = v.we; core_addr = v.addr; core_wdata = v.wdata;
        end
        for (int c = 0; c <= LAT + 2; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            chk("txn_mem_en", 32'(mem_en), 32'(c == 1));
            if (c == 1) begin
                chk("txn_mem_we", 32'(mem_we), 32'(v.we));
                chk("txn_mem_addr", 32'(mem_addr), 32'(v.addr));
                if (v.we) chk("txn_mem_wdata", mem_wdata, v.wdata);
            end
            chk("txn_core_ack", 32'(core_ack), 32'(!v.host && c == LAT + 2));
            chk("txn_host_ack", 32'(host_ack), 32'(v.host && c == LAT + 2));
            chk("txn_busy", 32'(busy), 32'(c != 0));
            chk("txn_core_stall", 32'(core_stall), 32'(!v.host && c < LAT + 2));
            if (c == LAT + 2) begin
                if (v.host) chk("txn_host_rdata", host_rdata, v.exp_rdata);
                else        chk("txn_core_rdata", core_rdata, v.exp_rdata);
            end
        end
        $display("txn %0d: %s %s addr=%03h wdata=%08h rdata=%08h", idx,
                 v.host ? "host" : "core", v.we ? "wr" : "rd", v.addr, v.wdata,
                 v.host ? host_rdata : core_rdata);
        @(posedge clk); #1;
        core_req = 1'b0; host_req = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; core_req = 1'b0; host_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Reference model state for the random phase.
    logic [DATA_W-1:0] ref_mem [0:1023];
    bit                m_active, m_port, m_we, m_last;
    int                m_g, m_cnt, t;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata, m_rd, e_core_rd, e_host_rd;
    bit                prev_core_ack, prev_host_ack;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b0, 1'b0, 10'h005, 32'h0,        32'hDEADBEEF};
        tbl[1] = '{1'b1, 1'b1, 10'h3FF, 32'h12345678, 32'h00000000};
        tbl[2] = '{1'b0, 1'b0, 10'h3FF, 32'h0,        32'h12345678};
        tbl[3] = '{1'b1, 1'b0, 10'h005, 32'h0,        32'hDEADBEEF};
        tbl[4] = '{1'b1, 1'b1, 10'h010, 32'hA5A5A5A5, 32'hDEADBEEF};
        tbl[5] = '{1'b0, 1'b1, 10'h020, 32'h0BADF00D, 32'h12345678};
        tbl[6] = '{1'b1, 1'b0, 10'h020, 32'h0,        32'h0BADF00D};
        tbl[7] = '{1'b0, 1'b0, 10'h010, 32'h0,        32'hA5A5A5A5};
        tbl[8] = '{1'b0, 1'b0, 10'h000, 32'h0,        32'h5A000000};

        rst_n = 1'b0; init_go = 1'b1;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        @(posedge clk); #1 init_go = 1'b0;
        @(negedge clk);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_core_ack", 32'(core_ack), 0);
        chk("rst_host_ack", 32'(host_ack), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_core_rdata", core_rdata, 0);
        chk("rst_host_rdata", host_rdata, 0);
        chk("rst_conflict", 32'(conflict_cnt), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 9; i++) do_txn(tbl[i], i);

        // Both ports request continuously out of reset: host, core, host, ...
        @(posedge clk); #1;
        rst_n = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 10'h005;
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'h3FF;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int tc = 0; tc < 100; tc++) begin
            bit ack_cyc, host_turn;
            int exp_cnt;
            if (tc > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            ack_cyc   = (tc % 5 == 4);
            host_turn = ((tc / 5) % 2 == 0);
            exp_cnt   = (tc == 0) ? 0 : ((tc - 1) / 5 + 1);
            if (exp_cnt > CNT_MAX) exp_cnt = CNT_MAX;
            chk("rr_host_ack", 32'(host_ack), 32'(ack_cyc && host_turn));
            chk("rr_core_ack", 32'(core_ack), 32'(ack_cyc && !host_turn));
            chk("rr_mem_en", 32'(mem_en), 32'(tc % 5 == 1));
            chk("rr_conflict", 32'(conflict_cnt), 32'(exp_cnt));
            if (ack_cyc && host_turn)  chk("rr_host_rdata", host_rdata, 32'h12345678);
            if (ack_cyc && !host_turn) chk("rr_core_rdata", core_rdata, 32'hDEADBEEF);
            if (ack_cyc) $display("contend grant %0d: %s ack at cycle %0d", tc / 5,
                                  host_turn ? "host" : "core", tc);
        end
        @(posedge clk); #1 core_req = 1'b0; host_req = 1'b0;

        // Asynchronous reset while a core read sits in WAIT.
        @(posedge clk); #1 core_req = 1'b1; core_we = 1'b0; core_addr = 10'h3FF;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0; core_req = 1'b0;
        #1;
        chk("arst_mem_en", 32'(mem_en), 0);
        chk("arst_mem_we", 32'(mem_we), 0);
        chk("arst_mem_addr", 32'(mem_addr), 0);
        chk("arst_mem_wdata", mem_wdata, 0);
        chk("arst_core_ack", 32'(core_ack), 0);
        chk("arst_host_ack", 32'(host_ack), 0);
        chk("arst_core_stall", 32'(core_stall), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_core_rdata", core_rdata, 0);
        chk("arst_host_rdata", host_rdata, 0);
        chk("arst_conflict", 32'(conflict_cnt), 0);
        repeat (3) begin
            @(negedge clk);
            chk("arst_hold_core_ack", 32'(core_ack), 0);
            chk("arst_hold_busy", 32'(busy), 0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        do_txn(tbl[0], 100);

        // last_gnt is core again, so a contended request must go to the host.
        @(posedge clk); #1;
        core_req = 1'b1; core_we = 1'b0; core_addr = 10'h005;
        host_req = 1'b1; host_we = 1'b0; host_addr = 10'h020;
        for (int c = 0; c <= LAT + 2; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            chk("lg_host_ack", 32'(host_ack), 32'(c == LAT + 2));
            chk("lg_core_ack", 32'(core_ack), 0);
        end
        chk("lg_host_rdata", host_rdata, 32'h0BADF00D);
        chk("lg_conflict", 32'(conflict_cnt), 1);
        @(posedge clk); #1 core_req = 1'b0; host_req = 1'b0;

        // Random traffic against the timeline model.
        do_reset();
        for (int a = 0; a < 1024; a++) ref_mem[a] = phys_mem[a];
        m_active = 0; m_last = 0; m_cnt = 0; m_g = 0; t = 0;
        m_port = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_rd = '0;
        e_core_rd = '0; e_host_rd = '0;
        prev_core_ack = 0; prev_host_ack = 0;
        for (int n = 0; n < 2000; n++) begin
            bit e_en, e_cack, e_hack, was_idle;
            @(posedge clk); #1;
            if (!core_req || prev_core_ack) begin
                core_req = 1'($urandom_range(0, 1));
                core_we = 1'($urandom_range(0, 1));
                core_addr = 10'($urandom_range(0, 7));
                core_wdata = $urandom;
            end else if ($urandom_range(0, 15) == 0) core_req = 1'b0;
            if (!host_req || prev_host_ack) begin
                host_req = 1'($urandom_range(0, 1));
                host_we = 1'($urandom_range(0, 1));
                host_addr = 10'($urandom_range(0, 7));
                host_wdata = $urandom;
            end else if ($urandom_range(0, 15) == 0) host_req = 1'b0;
            @(negedge clk);
            e_en   = m_active && (t == m_g + 1);
            e_cack = m_active && (t == m_g + LAT + 2) && !m_port;
            e_hack = m_active && (t == m_g + LAT + 2) && m_port;
            if (e_cack && !m_we) e_core_rd = m_rd;
            if (e_hack && !m_we) e_host_rd = m_rd;
            chk("rnd_mem_en", 32'(mem_en), 32'(e_en));
            chk("rnd_core_ack", 32'(core_ack), 32'(e_cack));
            chk("rnd_host_ack", 32'(host_ack), 32'(e_hack));
            chk("rnd_busy", 32'(busy), 32'(m_active));
            chk("rnd_core_stall", 32'(core_stall), 32'(core_req && !e_cack));
            chk("rnd_conflict", 32'(conflict_cnt), 32'(m_cnt));
            chk("rnd_core_rdata", core_rdata, e_core_rd);
            chk("rnd_host_rdata", host_rdata, e_host_rd);
            if (e_en) begin
                chk("rnd_mem_we", 32'(mem_we), 32'(m_we));
                chk("rnd_mem_addr", 32'(mem_addr), 32'(m_addr));
                if (m_we) chk("rnd_mem_wdata", mem_wdata, m_wdata);
            end
            prev_core_ack = e_cack;
            prev_host_ack = e_hack;
            was_idle = !m_active;
            if (m_active && t == m_g + LAT + 2) m_active = 0;
            if (was_idle && (core_req || host_req)) begin
                if (core_req && host_req) begin
                    m_port = !m_last;
                    if (m_cnt < CNT_MAX) m_cnt++;
                end else begin
                    m_port = host_req;
                end
                m_we    = m_port ? host_we    : core_we;
                m_addr  = m_port ? host_addr  : core_addr;
                m_wdata = m_port ? host_wdata : core_wdata;
                m_last  = m_port;
                m_active = 1;
                m_g = t;
                if (m_we) ref_mem[m_addr] = m_wdata;
                m_rd = ref_mem[m_addr];
            end
            t++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
